// File: rtl/spi_mem_bridge.sv
// SPI-slave to memory bridge: assembles LSB-first SPI frames into words, issues memory writes and reads, and returns read data on miso.
// Latency: pins are sampled 3 clk after an edge; mem_valid rises the cycle after the word completes; read data shifts out on the next word.
// Backpressure: a request holds mem_valid/addr/data stable until mem_ready; a word arriving during a pending request is dropped and flags err.
// Ports: clk, rst_n (async active-low); load_en enables the bridge; ss/sclk/mosi/miso are the SPI pins (async to clk);
//        mem_valid/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata form the memory request port; busy = not IDLE; err = sticky error.
// Optional feature: define SPI_MEM_BRIDGE_AUTO_INC_EN to make writes burst into consecutive addresses and reads auto-increment.
module spi_mem_bridge #(
  parameter int FRAME_SIZE  = 8,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 31,
  parameter bit CPOL        = 1'b0,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  ss,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int FPW = WORD_WIDTH / FRAME_SIZE;
  localparam int BCW = $clog2(FRAME_SIZE + 1);
  localparam int FCW = $clog2(FPW + 1);
  localparam int IW  = $clog2(WORD_WIDTH);
  localparam int GCW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_WDATA, ST_WREQ, ST_RREQ, ST_RDATA} state_e;

  state_e                state_q, state_d;
  logic [2:0]            ss_sync_q, sclk_sync_q;
  logic [1:0]            mosi_sync_q;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FCW-1:0]        frame_cnt_q, frame_cnt_d;
  logic [GCW-1:0]        gap_q, gap_d;
  logic [WORD_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  miso_q, miso_d, err_q, err_d;
  logic                  word_done, timeout;
  logic [IW-1:0]         idx;

  // Index 1 is the synchronised level; index 2 is its previous value for edge detection.
  // mosi uses the same depth so it is aligned with the sclk edge that samples it.
  logic ss_hi, ss_fall, ss_rise, sclk_edge, lead, trail, mosi_bit;
  assign ss_hi     = ss_sync_q[1];
  assign ss_fall   = ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
  assign sclk_edge = sclk_sync_q[2] ^ sclk_sync_q[1];
  assign lead      = sclk_edge & (sclk_sync_q[1] != CPOL);
  assign trail     = sclk_edge & (sclk_sync_q[1] == CPOL);
  assign mosi_bit  = mosi_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= {3{CPOL}};
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      gap_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], ss};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    gap_d       = gap_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    err_d       = err_q;
    word_done   = 1'b0;
    timeout     = 1'b0;
    idx         = IW'(frame_cnt_q) * IW'(FRAME_SIZE) + IW'(bit_cnt_q);

    if (!load_en) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      frame_cnt_d = '0;
      gap_d       = '0;
      miso_d      = 1'b0;
      err_d       = 1'b0;
    end else begin
      // Gap counter saturates so the timeout fires exactly once per idle period.
      if (ss_hi) begin
        if (gap_q != GCW'(GAP_TIMEOUT)) gap_d = gap_q + 1'b1;
      end else begin
        gap_d = '0;
      end
      timeout = ss_hi && (gap_q == GCW'(GAP_TIMEOUT - 1));

      // Receive: bits land directly at their word position, so a discarded partial
      // frame is simply overwritten by the next full one.
      if (state_q != ST_IDLE && !ss_hi && trail) begin
        for (int i = 0; i < WORD_WIDTH; i++) begin
          if (idx == IW'(i)) rx_d[i] = mosi_bit;
        end
        if (bit_cnt_q == BCW'(FRAME_SIZE - 1)) begin
          bit_cnt_d = '0;
          if (frame_cnt_q == FCW'(FPW - 1)) begin
            frame_cnt_d = '0;
            word_done   = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      if (state_q != ST_IDLE && ss_rise && bit_cnt_q != '0) begin
        bit_cnt_d = '0;
        err_d     = 1'b1;
      end

      // Transmit: while the read is still pending there is nothing valid to send.
      if (ss_hi) begin
        miso_d = 1'b0;
      end else if (state_q != ST_IDLE && lead) begin
        if (state_q == ST_RREQ) begin
          miso_d = 1'b0;
          if (bit_cnt_q == '0) err_d = 1'b1;
        end else begin
          miso_d = tx_q[0];
          tx_d   = tx_q >> 1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          bit_cnt_d   = '0;
          frame_cnt_d = '0;
          if (ss_fall) state_d = ST_ADDR;
        end
        ST_ADDR: begin
          if (word_done) begin
            addr_d  = rx_d[ADDR_WIDTH:1];
            state_d = rx_d[0] ? ST_WDATA : ST_RREQ;
          end
        end
        ST_WDATA: begin
          if (word_done) begin
            wdata_d = rx_d;
            state_d = ST_WREQ;
          end
        end
        ST_WREQ: begin
          if (word_done) err_d = 1'b1;
          if (mem_ready) begin
`ifdef SPI_MEM_BRIDGE_AUTO_INC_EN
            addr_d  = addr_q + 1'b1;
            state_d = ST_WDATA;
`else
            state_d = ST_ADDR;
`endif
          end
        end
        ST_RREQ: begin
          if (word_done) err_d = 1'b1;
          if (mem_ready) begin
            tx_d    = mem_rdata;
            state_d = ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (word_done) begin
`ifdef SPI_MEM_BRIDGE_AUTO_INC_EN
            addr_d  = addr_q + 1'b1;
            state_d = ST_RREQ;
`else
            state_d = ST_ADDR;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A pending memory request is never abandoned by the gap timer: dropping it
      // would silently lose an accepted write.
      if (timeout && state_q != ST_WREQ && state_q != ST_RREQ) begin
        if (bit_cnt_q != '0 || frame_cnt_q != '0) err_d = 1'b1;
        bit_cnt_d   = '0;
        frame_cnt_d = '0;
        state_d     = ST_IDLE;
      end
    end
  end

  assign miso      = miso_q;
  assign mem_valid = (state_q == ST_WREQ) || (state_q == ST_RREQ);
  assign mem_we    = (state_q == ST_WREQ);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: doc/spi_mem_bridge.md
Name: spi_mem_bridge

Overview:
- Parametrised SPI-slave-to-memory bridge. Used by the loader path to write program/data words into on-chip memory and, new in this generation, to read them back over MISO.
- Serial frames are FRAME_SIZE bits, sent LSB first, and `ss` is pulsed per frame. FRAMES_PER_WORD frames, least-significant frame first, form one WORD_WIDTH word.
- Each transaction is an address word followed by a data word. Address word bit0 selects the operation: 1 = write, 0 = read.
- Sits between the external SPI pins and the memory arbiter. Active only while `load_en` = 1; the core owns memory otherwise.

Parameters:
- FRAME_SIZE, 8, bits per SPI frame.
- WORD_WIDTH, 32, assembled word width; must be an integer multiple of FRAME_SIZE.
- ADDR_WIDTH, 31, memory word-address width; must be ≤ WORD_WIDTH-1.
- CPOL, 0, idle `sclk` level. Leading edge = transition away from idle; trailing edge = transition back to idle.
- GAP_TIMEOUT, 64, number of `clk` cycles with `ss` high after which a partial word/transaction is abandoned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  1 = bridge active; 0 = ignore SPI, hold in IDLE
- ss  in  1  SPI slave select, active low, asynchronous to `clk`
- sclk  in  1  SPI clock, asynchronous to `clk`
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- mem_valid  out  1  memory request valid
- mem_we  out  1  1 = write request, 0 = read request
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  WORD_WIDTH  write data
- mem_ready  in  1  memory accepts the request; `mem_rdata` is valid in the same cycle for reads
- mem_rdata  in  WORD_WIDTH  read data
- busy  out  1  1 while a transaction is in progress (state ≠ IDLE)
- err  out  1  sticky error flag; cleared by reset or by `load_en` falling

Behaviour:
- Reset values: `miso` = 0, `mem_valid` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0, `err` = 0. All shift registers, counters and the state register clear asynchronously.
- Input synchronisation:
  - `ss`, `sclk` and `mosi` each pass through a 2-FF synchroniser, then an edge detector.
  - `sclk` must hold each level for ≥2 `clk` cycles.
  - Sampling happens 3 `clk` cycles after the pin edge.
- Bit level:
  - On a synchronised trailing edge with `ss` low: shift `mosi` into the receive register at bit position `bit_cnt`, then increment `bit_cnt`.
  - On a synchronised leading edge with `ss` low: drive `miso` = `tx_shift[0]`, then shift `tx_shift` right.
  - `miso` = 0 whenever `ss` is high.
- Frame level:
  - A frame is complete when `bit_cnt` reaches FRAME_SIZE; `frame_cnt` then increments.
  - If `ss` rises with `bit_cnt` ≠ 0 and ≠ FRAME_SIZE: discard the frame, set `err`, keep `frame_cnt`.
- Word level: a word is complete when `frame_cnt` reaches WORD_WIDTH/FRAME_SIZE. Counters then reset and the word is passed to the FSM.
- Gap timer: counts `clk` cycles while `ss` is high and resets when `ss` goes low. On reaching GAP_TIMEOUT, clear `bit_cnt` and `frame_cnt`, go to IDLE, and set `err` only if a word was partially received.
- FSM states: IDLE, ADDR, WDATA, WREQ, RREQ, RDATA.
  - IDLE → ADDR: `load_en` = 1 and `ss` falls.
  - ADDR, on word complete: latch `mem_addr` = `word[ADDR_WIDTH:1]`. Go to WDATA if bit0 = 1, else RREQ.
  - WDATA, on word complete: latch `mem_wdata`, go to WREQ.
  - WREQ: `mem_valid` = 1, `mem_we` = 1. `mem_valid` rises the cycle after word complete and is held with stable addr/data until `mem_ready` is sampled 1. Next state: ADDR (or WDATA with AUTO_INC_EN).
  - RREQ: `mem_valid` = 1, `mem_we` = 0. On `mem_ready`, load `tx_shift` = `mem_rdata` and go to RDATA.
  - RDATA: the next word is shifted out on `miso`, LSB first; `mosi` is ignored. On word complete, go to ADDR.
- Boundary cases:
  - A word that completes while in WREQ or RREQ is dropped and sets `err`.
  - An SPI frame that starts in RREQ shifts out 0s and sets `err`.
- `load_en` falling: abort immediately to IDLE, deassert `mem_valid` the next cycle, clear counters and `err`.
- `busy` = 1 in every state except IDLE.

Optional Feature:
- Macro SPI_MEM_BRIDGE_AUTO_INC_EN.
- Defined: after WREQ completes, go to WDATA instead of ADDR with `mem_addr` + 1, wrapping modulo 2^ADDR_WIDTH. Consecutive data words burst-write until the gap timer fires, which returns to IDLE without setting `err`. Read then also auto-increments: RDATA returns to RREQ at `mem_addr` + 1.
- Undefined: strict address/data pairs as described above.

Test Plan:
- Write: address word 0x00000009 then data 0xDEADBEEF (per-frame `ss`, 2 `clk` per `sclk` half) → one `mem_valid` pulse with `mem_we` = 1, `mem_addr` = 4, `mem_wdata` = 0xDEADBEEF. Hold `mem_ready` low 5 cycles → request stays stable; `err` = 0.
- Read: write 0x12345678 at address 4, then send 0x00000008 and shift 4 frames → MISO frames 0x78, 0x56, 0x34, 0x12.
- Abort: send a 5-bit partial frame then raise `ss` → `err` = 1, no memory request. Drop `load_en` → `err` = 0, `busy` = 0.
- Timeout: send 2 frames of an address word, idle 64 cycles → IDLE; the next 8 frames are decoded as a fresh address/data pair.
- Collision: hold `mem_ready` = 0 while a new word arrives → word dropped, `err` = 1.
- With AUTO_INC_EN: address 0x00000001, data 0xA, 0xB, 0xC, then idle → writes at addresses 0, 1, 2; `err` = 0.
